uart_rx: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5,
        DONE   = 3'd6
    } rx_state_t;

    // Expected parity bit for a byte: even parity is the XOR of the data, odd inverts it.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic reset_value,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= reset_value;
            q    <= reset_value;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: input sync, mid-bit sampling, parity/stop checks, one-entry output buffer
module uart_rx
    import uart_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic        o_rts,
    input  logic        i_hw_flow_control_enable,
    input  logic [31:0] i_bit_length,
    input  logic        i_msb_first,
    input  logic        i_parity_enable,
    input  logic        i_parity_odd,
    input  logic        i_two_stop_bits,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_overrun
);

    rx_state_t   state;
    rx_state_t   next_state;
    logic        rx_s;
    logic        armed;
    logic [31:0] cnt;
    logic [31:0] bit_len_q;
    logic        msb_first_q;
    logic        par_en_q;
    logic        par_odd_q;
    logic        two_stop_q;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        par_err_q;
    logic        frame_err_q;
    logic        half_pt;
    logic        full_pt;
    logic        start_det;
    logic        cnt_clr;
    logic        data_smp;
    logic        par_smp;
    logic        stop_smp;
    logic        stop_bad;
    logic        frame_end;

    uart_sync2 u_sync (
        .clk         (i_clk),
        .rst         (i_rst),
        .reset_value (1'b1),
        .d           (i_rx),
        .q           (rx_s)
    );

    assign half_pt = (cnt == (bit_len_q >> 1));
    assign full_pt = (cnt == bit_len_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s && armed) next_state = START;
            START:   if (half_pt) next_state = rx_s ? IDLE : DATA;
            DATA:    if (full_pt && bit_idx == 3'd7) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (full_pt) next_state = STOP;
            STOP:    if (full_pt) next_state = two_stop_q ? STOP2 : DONE;
            STOP2:   if (full_pt) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_det = (state == IDLE) && !rx_s && armed;
        data_smp  = (state == DATA) && full_pt;
        par_smp   = (state == PARITY) && full_pt;
        stop_smp  = ((state == STOP) || (state == STOP2)) && full_pt;
        stop_bad  = stop_smp && !rx_s;
        frame_end = stop_smp && ((state == STOP2) || !two_stop_q);
        cnt_clr   = start_det || ((state == START) && half_pt) || data_smp || par_smp || stop_smp;
        o_rts     = i_hw_flow_control_enable ? !o_valid : 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt         <= 32'd0;
            bit_len_q   <= 32'd0;
            msb_first_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            armed       <= 1'b1;
        end else begin
            if ((state == IDLE) || cnt_clr) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            if (start_det) begin
                bit_len_q   <= i_bit_length;
                msb_first_q <= i_msb_first;
                par_en_q    <= i_parity_enable;
                par_odd_q   <= i_parity_odd;
                two_stop_q  <= i_two_stop_bits;
                bit_idx     <= 3'd0;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            if (data_smp) begin
                shift   <= msb_first_q ? {shift[6:0], rx_s} : {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (par_smp) begin
                par_err_q <= (rx_s != calc_parity(shift, par_odd_q));
            end

            if (stop_bad) begin
                frame_err_q <= 1'b1;
            end

            // A framing error may be a break; wait for the line to go high before re-arming.
            if (frame_end && (frame_err_q || stop_bad)) begin
                armed <= 1'b0;
            end else if (rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // The buffer loads on the edge into DONE, so o_valid rises one clock after the last stop sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_data       <= 8'd0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (frame_end) begin
                if (!o_valid || i_ready) begin
                    o_valid      <= 1'b1;
                    o_data       <= shift;
                    o_parity_err <= par_err_q;
                    o_frame_err  <= frame_err_q || stop_bad;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
